stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Sequences the stopwatch datapath from single-cycle debounced button pulses
//   (start/stop, lap, clear). Owns the centisecond prescaler, the BCD mm:ss.cc
//   time counter and the lap-freeze display latch. Sits between the per-button
//   debouncers and the seven-segment display drivers.
// PARAMETERS
//   CLK_HZ   50_000_000  input clock frequency
//   TICK_HZ  100         time-counter increment rate; DIV = CLK_HZ/TICK_HZ, must be >= 2
// PORTS
//   CLOCK_50      in   1  system clock, all logic on posedge
//   reset         in   1  synchronous, active-high
//   ss_pulse      in   1  start/stop press, one-cycle pulse
//   lap_pulse     in   1  lap press, one-cycle pulse
//   clr_pulse     in   1  clear press, one-cycle pulse
//   running       out  1  1 in RUN or LAP
//   lap_active    out  1  1 in LAP (display frozen)
//   overflow      out  1  sticky, set on 59:59.99 -> 00:00.00 wrap
//   disp          out  24 BCD {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4 bits each
// BEHAVIOUR
//   Reset: state IDLE, prescaler 0, time 00:00.00, lap latch 0, all outputs 0.
//   States: IDLE, RUN, PAUSE, LAP.
//   Pulse priority, same cycle: clr > ss > lap; lower-priority pulses are dropped.
//   Transitions, one cycle after the accepted pulse:
//     IDLE : ss -> RUN; lap and clr ignored (clr leaves time at zero).
//     RUN  : ss -> PAUSE; lap -> LAP, latch the time value held in that cycle
//            (pre-increment if a tick coincides); clr ignored.
//     LAP  : lap -> RUN (display live again); ss -> PAUSE (display live); clr ignored.
//     PAUSE: ss -> RUN; clr -> IDLE, zero the prescaler, time and overflow; lap ignored.
//   Prescaler: counts 0..DIV-1 only in RUN/LAP. tick=1 in the cycle count==DIV-1,
//     and count wraps to 0. Holds its value in PAUSE, so a resume keeps the
//     fractional period. Zeroed only by reset or an accepted clr.
//   Time counter: on tick, increments as a BCD cascade. cs 00-99, sec 00-59, min 00-59.
//     Each digit carries only when all lower digits are at max.
//     59:59.99 + tick -> 00:00.00, overflow<=1, and counting continues.
//   Display: disp = lap latch in LAP, otherwise the live time. Registered output:
//     disp reflects a counter update or state change 1 cycle later.
//   The state change and tick counting take effect in the same cycle: a tick
//     coincident with ss in RUN still increments the time.
//   running, lap_active and overflow are registered and decoded from the next state.
//   Reset mid-count: all state is lost, and the outputs read zero on the next edge.
// STRUCTURE
//   sw_pkg: state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3), BCD digit max
//     constants (9, 5), disp field offsets.
//   Sub-module sw_time_counter: BCD cascade with inputs tick and clr and outputs
//     the 24-bit value and wrap. The FSM, prescaler and lap latch stay in
//     stopwatch_ctrl.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//   1. reset; ss at cycle 5 -> running=1 at cycle 6; first tick 10 cycles later;
//      disp=000001 one cycle after it.
//   2. Run to 00:00.37, lap -> lap_active=1 and disp frozen at 000037 while the live
//      count advances. A second lap -> disp shows the live value (e.g. 000042) next cycle.
//   3. ss after 4 prescaler counts (PAUSE), wait 100 cycles, ss -> next tick arrives
//      exactly 6 running cycles later; disp unchanged during PAUSE.
//   4. clr during RUN -> ignored. ss, then clr -> IDLE, disp=000000, overflow=0.
//   5. Preload 59:59.99 through the sub-module force or run to it, then one tick ->
//      disp=000000, overflow=1 and sticky, counting continues.
//   6. clr+ss+lap together in PAUSE -> IDLE. ss+lap together in RUN -> PAUSE with
//      lap_active=0. reset asserted in LAP -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
//   Shared definitions for the stopwatch controller: FSM state encoding,
//   decoded button-press type, BCD digit limits and the field layout of the
//   24-bit mm:ss.cc display word.
// -----------------------------------------------------------------------------
package sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // The single press that wins arbitration in a given cycle.
    typedef enum logic [1:0] {
        PB_NONE = 2'd0,
        PB_SS   = 2'd1,
        PB_LAP  = 2'd2,
        PB_CLR  = 2'd3
    } sw_press_e;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;   // any units digit, and the cs tens digit
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;   // tens of seconds and of minutes

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int DISP_W     = DIGIT_W * NUM_DIGITS;

    // Bit offsets of each digit in {min_t,min_u,sec_t,sec_u,cs_t,cs_u}.
    localparam int CS_U_LSB  = 0;
    localparam int CS_T_LSB  = 4;
    localparam int SEC_U_LSB = 8;
    localparam int SEC_T_LSB = 12;
    localparam int MIN_U_LSB = 16;
    localparam int MIN_T_LSB = 20;

    // Largest legal value of digit idx (0 = cs_u ... 5 = min_t).
    function automatic logic [3:0] digit_max(input int idx);
        return (idx * DIGIT_W == SEC_T_LSB || idx * DIGIT_W == MIN_T_LSB)
               ? BCD_MAX_TENS : BCD_MAX_UNITS;
    endfunction

    // Fixed priority clr > ss > lap; losers are discarded, not queued.
    function automatic sw_press_e select_press(input logic ss, input logic lap,
                                               input logic clr);
        if (clr)      return PB_CLR;
        else if (ss)  return PB_SS;
        else if (lap) return PB_LAP;
        else          return PB_NONE;
    endfunction

endpackage

// File: rtl/sw_time_counter.sv
// -----------------------------------------------------------------------------
// sw_time_counter
//   Six-digit BCD mm:ss.cc counter (00:00.00 .. 59:59.99).
// Ports
//   clk    in   1   clock, posedge
//   reset  in   1   synchronous, active-high
//   tick   in   1   advance by one centisecond
//   clr    in   1   synchronous zero, wins over tick
//   value  out  24  current count {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
//   wrap   out  1   high in the cycle a tick rolls 59:59.99 over to 00:00.00
// -----------------------------------------------------------------------------
module sw_time_counter
    import sw_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              clr,
    output logic [DISP_W-1:0] value,
    output logic              wrap
);

    logic [DISP_W-1:0] cnt_q;
    logic [DISP_W-1:0] cnt_d;
    logic              carry;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps a combinational block from becoming a latch.
    always_comb begin
        cnt_d = cnt_q;
        carry = tick;
        // Ripple the increment upward: a digit moves only while every digit
        // below it was at its maximum, which is exactly when carry survives.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[i*DIGIT_W +: DIGIT_W] == digit_max(i)) begin
                    cnt_d[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    cnt_d[i*DIGIT_W +: DIGIT_W] = cnt_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        wrap = carry;   // carry out of min_t: all six digits were at max
        if (clr) begin
            cnt_d = '0;
            wrap  = 1'b0;
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Stopwatch sequencer: IDLE/RUN/PAUSE/LAP FSM driven by one-cycle debounced
//   button pulses, centisecond prescaler, BCD time counter and lap-freeze
//   display latch.
// Parameters
//   CLK_HZ   input clock frequency
//   TICK_HZ  time-counter increment rate; CLK_HZ/TICK_HZ must be >= 2
// Ports
//   CLOCK_50    in   1   system clock, posedge
//   reset       in   1   synchronous, active-high
//   ss_pulse    in   1   start/stop press
//   lap_pulse   in   1   lap press
//   clr_pulse   in   1   clear press
//   running     out  1   state is RUN or LAP
//   lap_active  out  1   state is LAP (display frozen)
//   overflow    out  1   sticky, set on 59:59.99 -> 00:00.00
//   disp        out  24  BCD {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        ss_pulse,
    input  logic        lap_pulse,
    input  logic        clr_pulse,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic [23:0] disp
);

    localparam int            DIV        = CLK_HZ / TICK_HZ;
    localparam int            PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    sw_state_e         state_q,      state_d;
    logic [PW-1:0]     presc_q,      presc_d;
    logic [DISP_W-1:0] lap_q,        lap_d;
    logic [DISP_W-1:0] disp_q,       disp_d;
    logic              running_q,    running_d;
    logic              lap_active_q, lap_active_d;
    logic              overflow_q,   overflow_d;

    sw_press_e         press;
    logic              counting;
    logic              tick;
    logic              clr_time;
    logic [DISP_W-1:0] time_value;
    logic              time_wrap;

    // Next-state logic. Transitions depend on the current state; the press
    // that lost arbitration is simply gone.
    always_comb begin
        state_d  = state_q;
        clr_time = 1'b0;
        press    = select_press(ss_pulse, lap_pulse, clr_pulse);
        unique case (state_q)
            ST_IDLE: begin
                if (press == PB_SS) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (press == PB_SS)       state_d = ST_PAUSE;
                else if (press == PB_LAP) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (press == PB_SS)       state_d = ST_PAUSE;
                else if (press == PB_LAP) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (press == PB_SS) begin
                    state_d = ST_RUN;
                end else if (press == PB_CLR) begin
                    state_d  = ST_IDLE;
                    clr_time = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath. Counting follows the current state, so the cycle that accepts
    // a stop still counts and a tick landing there still reaches the time.
    always_comb begin
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick     = counting && (presc_q == PRESC_LAST);

        presc_d = presc_q;               // PAUSE holds the fractional period
        if (clr_time)      presc_d = '0;
        else if (tick)     presc_d = '0;
        else if (counting) presc_d = presc_q + 1'b1;

        lap_d = lap_q;                   // captures the pre-increment value
        if (state_q == ST_RUN && press == PB_LAP) lap_d = time_value;

        overflow_d = overflow_q;
        if (clr_time)       overflow_d = 1'b0;
        else if (time_wrap) overflow_d = 1'b1;

        running_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
        lap_active_d = (state_d == ST_LAP);
        disp_d       = (state_q == ST_LAP) ? lap_q : time_value;
    end

    sw_time_counter u_time_counter (
        .clk   (CLOCK_50),
        .reset (reset),
        .tick  (tick),
        .clr   (clr_time),
        .value (time_value),
        .wrap  (time_wrap)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            lap_q        <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
        end
    end

    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;
    assign disp       = disp_q;

endmodule
